// File: rtl/sram_resp_pkg.sv
// Purpose: shared state encoding and constants for the asynchronous-style SRAM responder.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package sram_resp_pkg;

  localparam int WAIT_W = 4;   // wait-state counter width, covers 0..15
  localparam int DATA_W = 16;
  localparam int ADDR_W = 20;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    RD_DRIVE,
    WR_COMMIT,
    HOLD
  } state_t;

endpackage

// File: rtl/sram_responder_if.sv
// Purpose: initiator-side control/address strobes and responder status of the SRAM port.
// Latency: n/a (wires only).
// Backpressure: none; the initiator holds strobes until Mem_Ready is seen.
// Ports: CE/OE/WE/UB/LB active-low strobes, ADDR word address, Mem_Ready/Addr_Err status.
interface sram_responder_if;
  import sram_resp_pkg::*;

  logic              CE;
  logic              OE;
  logic              WE;
  logic              UB;
  logic              LB;
  logic [ADDR_W-1:0] ADDR;
  logic              Mem_Ready;
  logic              Addr_Err;

  modport master (output CE, OE, WE, UB, LB, ADDR, input Mem_Ready, Addr_Err);
  modport slave  (input CE, OE, WE, UB, LB, ADDR, output Mem_Ready, Addr_Err);

endinterface

// File: rtl/sram_array.sv
// Purpose: single-port word storage with byte-masked synchronous write and registered read.
// Latency: read word available one edge after rd_en; write lands on the edge with wr_be set.
// Backpressure: none; accepts an access every cycle.
// Ports: clk, addr, rd_en, wr_be[1]=upper byte / wr_be[0]=lower byte, wr_dat, rd_dat.
module sram_array
  import sram_resp_pkg::*;
#(
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic                 rd_en,
  input  logic [1:0]           wr_be,
  input  logic [DATA_W-1:0]    wr_dat,
  output logic [DATA_W-1:0]    rd_dat
);

  // No reset on purpose: contents must survive a responder reset.
  logic [DATA_W-1:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (wr_be[1]) mem[addr][15:8] <= wr_dat[15:8];
    if (wr_be[0]) mem[addr][7:0]  <= wr_dat[7:0];
    if (rd_en)    rd_dat          <= mem[addr];
  end

endmodule

// File: rtl/sram_responder.sv
// Purpose: SRAM-style target: decodes CE/OE/WE strobes, inserts wait states, drives or commits a word.
// Latency: Mem_Ready rises WAIT_STATES+1 edges after the start, counting the sampling edge as the first.
// Backpressure: none; read data is held until CE/OE rise, a write commits once per CE/WE assertion.
// Ports: Clk, Reset (async, active-low), bus (slave strobes/status), Data (shared tri-state bus).
module sram_responder
  import sram_resp_pkg::*;
#(
  parameter int ADDR_BITS   = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  sram_responder_if.slave   bus,
  inout  wire  [DATA_W-1:0] Data
);

  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_STATES);

  state_t               state_q, state_d;
  logic [WAIT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_BITS-1:0] addr_q;
  logic                 wr_q, ub_q, lb_q, oow_q, addr_err_q;

  logic                 start, start_wr, oow_in, oow_cur, latch;
  logic                 enter_rd, enter_wr, drv_en;
  logic [ADDR_BITS-1:0] arr_addr;
  logic [1:0]           wr_be;
  logic [DATA_W-1:0]    arr_rd;

  // WE low wins over OE low, so CE=WE=OE=0 is a write.
  assign start    = !bus.CE && (!bus.WE || !bus.OE);
  assign start_wr = !bus.WE;
  assign oow_in   = (bus.ADDR >> ADDR_BITS) != '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    latch   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          latch = 1'b1;
          cnt_d = WAIT_LOAD;
          if (WAIT_STATES == 0) state_d = start_wr ? WR_COMMIT : RD_DRIVE;
          else                  state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.CE) begin
          // Abort: nothing has been driven or committed yet.
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q <= WAIT_W'(1)) begin
          cnt_d   = '0;
          state_d = wr_q ? WR_COMMIT : RD_DRIVE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RD_DRIVE:  if (bus.CE || bus.OE) state_d = IDLE;
      WR_COMMIT: state_d = HOLD;
      // Only a strobe release re-arms the block: one write per assertion.
      HOLD:      if (bus.CE || bus.WE) state_d = IDLE;
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign enter_rd = (state_d == RD_DRIVE) && (state_q != RD_DRIVE);
  assign enter_wr = (state_d == WR_COMMIT);
  // With zero wait states the access completes straight from IDLE, before the latch holds it.
  assign oow_cur  = (state_q == IDLE) ? oow_in : oow_q;
  assign arr_addr = (state_q == IDLE) ? bus.ADDR[ADDR_BITS-1:0] : addr_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wr_q       <= 1'b0;
      ub_q       <= 1'b1;
      lb_q       <= 1'b1;
      oow_q      <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_err_q <= (enter_rd || enter_wr) && oow_cur;
      if (latch) begin
        addr_q <= bus.ADDR[ADDR_BITS-1:0];
        wr_q   <= start_wr;
        ub_q   <= bus.UB;
        lb_q   <= bus.LB;
        oow_q  <= oow_in;
      end
    end
  end

  // Gated by the live state, so an async reset cancels a pending commit.
  assign wr_be = (state_q == WR_COMMIT && !oow_q) ? {~ub_q, ~lb_q} : 2'b00;

  sram_array #(.ADDR_BITS(ADDR_BITS)) u_array (
    .clk    (Clk),
    .addr   (arr_addr),
    .rd_en  (enter_rd),
    .wr_be  (wr_be),
    .wr_dat (Data),
    .rd_dat (arr_rd)
  );

  // Combinational enable so the bus is released in the same cycle OE/CE rise.
  assign drv_en = (state_q == RD_DRIVE) && !bus.CE && !bus.OE && bus.WE;
  assign Data   = drv_en ? (oow_q ? {DATA_W{1'b0}} : arr_rd) : {DATA_W{1'bz}};

  assign bus.Mem_Ready = (state_q == RD_DRIVE) || (state_q == WR_COMMIT);
  assign bus.Addr_Err  = addr_err_q;

endmodule
